// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, FSM state encoding
// and a rotate helper used by the Sigma blocks.
package sha256_pkg;

  localparam int unsigned WORD   = 32;
  localparam int unsigned ROUNDS = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } state_e;

  localparam logic [WORD-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [8*WORD-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD - n));
  endfunction

endpackage

// File: rtl/sha256_round_core_if.sv
// Block-level handshake bundle for sha256_round_core: start/chaining input, schedule word
// stream and digest/status outputs.
interface sha256_round_core_if;
  import sha256_pkg::*;

  logic              start_in;
  logic [8*WORD-1:0] hash_in;
  logic              w_valid_in;
  logic [WORD-1:0]   w_in;
  logic              w_ready_out;
  logic [8*WORD-1:0] hash_out;
  logic              done_out;
  logic              busy_out;

  modport master (
    output start_in, hash_in, w_valid_in, w_in,
    input  w_ready_out, hash_out, done_out, busy_out
  );

  modport slave (
    input  start_in, hash_in, w_valid_in, w_in,
    output w_ready_out, hash_out, done_out, busy_out
  );
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant K[t].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]      idx_i,
  output logic [WORD-1:0] k_o
);
  assign k_o = K[idx_i];
endmodule

// File: rtl/sha256_sigma.sv
// Big-sigma function: XOR of three right-rotations of a word (EP0 / EP1 by parameter).
module sha256_sigma
  import sha256_pkg::*;
#(
  parameter int unsigned R0 = 2,
  parameter int unsigned R1 = 13,
  parameter int unsigned R2 = 22
) (
  input  logic [WORD-1:0] x_i,
  output logic [WORD-1:0] y_o
);
  assign y_o = rotr(x_i, R0) ^ rotr(x_i, R1) ^ rotr(x_i, R2);
endmodule

// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression: one round per accepted schedule word, then a feed-forward add.
// Optional debug taps (round index, working variable a) under `SHA256_ROUND_DBG_EN.
module sha256_round_core
  import sha256_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROUNDS     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  sha256_round_core_if.slave    bus
`ifdef SHA256_ROUND_DBG_EN
  ,
  output logic [6:0]            dbg_round_out,
  output logic [DATA_WIDTH-1:0] dbg_a_out
`endif
);

  state_e state_q, state_d;
  logic [6:0] t_q, t_d;
  // Word 7 is a / H0 so the packed layout matches hash_in (H0 in the MSBs).
  logic [7:0][DATA_WIDTH-1:0] var_q, var_d;
  logic [7:0][DATA_WIDTH-1:0] hsave_q, hsave_d;
  logic [7:0][DATA_WIDTH-1:0] hash_q, hash_d;
  logic done_q, done_d;

  logic [DATA_WIDTH-1:0] ep0, ep1, ch, maj, k_t, t1, t2;

  sha256_sigma #(.R0(2), .R1(13), .R2(22)) u_ep0 (.x_i(var_q[7]), .y_o(ep0));
  sha256_sigma #(.R0(6), .R1(11), .R2(25)) u_ep1 (.x_i(var_q[3]), .y_o(ep1));
  sha256_k_rom u_k_rom (.idx_i(t_q[5:0]), .k_o(k_t));

  always_comb begin
    ch  = (var_q[3] & var_q[2]) ^ (~var_q[3] & var_q[1]);
    maj = (var_q[7] & var_q[6]) ^ (var_q[7] & var_q[5]) ^ (var_q[6] & var_q[5]);
    t1  = var_q[0] + ep1 + ch + k_t + bus.w_in;
    t2  = ep0 + maj;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    var_d   = var_q;
    hsave_d = hsave_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          state_d = StRound;
          hsave_d = bus.hash_in;
          var_d   = bus.hash_in;
          t_d     = '0;
        end
      end
      StRound: begin
        if (bus.w_valid_in) begin
          var_d = {t1 + t2, var_q[7], var_q[6], var_q[5],
                   var_q[4] + t1, var_q[3], var_q[2], var_q[1]};
          t_d   = t_q + 7'd1;
          if (t_q == 7'(ROUNDS - 1)) state_d = StFinal;
        end
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) hash_d[i] = hsave_q[i] + var_q[i];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      var_q   <= '0;
      hsave_q <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      var_q   <= var_d;
      hsave_q <= hsave_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
    end
  end

  assign bus.w_ready_out = (state_q == StRound);
  // Busy stays up through the done cycle so it falls one edge after the digest appears.
  assign bus.busy_out    = (state_q != StIdle) || done_q;
  assign bus.hash_out    = hash_q;
  assign bus.done_out    = done_q;

`ifdef SHA256_ROUND_DBG_EN
  assign dbg_round_out = t_q;
  assign dbg_a_out     = var_q[7];
`endif

endmodule
